// File: rtl/freq_gen_n.sv
// Programmable square-wave generator: fout is high for N clk cycles, then low
// for N cycles. A new N is double-buffered and applied only at a period boundary.
module freq_gen_n #(
  parameter int N_W = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           en,
  input  logic [N_W-1:0] n_in,
  input  logic           n_load,
  output logic           fout,
  output logic [N_W-1:0] n_active,
  output logic           period_done,
  output logic           n_err,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [N_W-1:0] ONE  = {{(N_W-1){1'b0}}, 1'b1};
  localparam logic [N_W-1:0] ZERO = '0;

  state_t         state_q, state_d;
  logic [N_W-1:0] hc_q, hc_d;
  logic [N_W-1:0] n_active_q, n_active_d;
  logic [N_W-1:0] shadow_q, shadow_d;
  logic           pending_q, pending_d;
  logic           fout_q, fout_d;
  logic           period_done_q, period_done_d;
  logic           n_err_q, n_err_d;
  logic           busy_q, busy_d;

  logic           load_ok;
  logic           phase_end;
  logic [N_W-1:0] eff_n;

  always_comb begin
    load_ok   = n_load && (n_in != ZERO);
    phase_end = (hc_q == n_active_q);
    // A valid load in a commit cycle bypasses the shadow register.
    eff_n     = load_ok ? n_in : (pending_q ? shadow_q : n_active_q);

    state_d    = state_q;
    hc_d       = hc_q;
    n_active_d = n_active_q;
    shadow_d   = load_ok ? n_in : shadow_q;
    pending_d  = load_ok | pending_q;

    case (state_q)
      IDLE: begin
        hc_d = ZERO;
        if (en && (eff_n != ZERO)) begin
          state_d    = HIGH;
          hc_d       = ONE;
          n_active_d = eff_n;
          pending_d  = 1'b0;
        end
      end
      HIGH: begin
        hc_d = hc_q + ONE;
        if (phase_end) begin
          state_d = LOW;
          hc_d    = ONE;
        end
      end
      LOW: begin
        hc_d = hc_q + ONE;
        if (phase_end) begin
          if (en) begin
            state_d    = HIGH;
            hc_d       = ONE;
            n_active_d = eff_n;
            pending_d  = 1'b0;
          end else begin
            state_d = IDLE;
            hc_d    = ZERO;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hc_d    = ZERO;
      end
    endcase

    // Outputs are computed from the next state so they appear registered.
    fout_d        = (state_d == HIGH);
    busy_d        = (state_d != IDLE);
    period_done_d = (state_d == LOW) && (hc_d == n_active_d);
    n_err_d       = n_load && (n_in == ZERO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hc_q          <= ZERO;
      n_active_q    <= ZERO;
      shadow_q      <= ZERO;
      pending_q     <= 1'b0;
      fout_q        <= 1'b0;
      period_done_q <= 1'b0;
      n_err_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hc_q          <= hc_d;
      n_active_q    <= n_active_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      fout_q        <= fout_d;
      period_done_q <= period_done_d;
      n_err_q       <= n_err_d;
      busy_q        <= busy_d;
    end
  end

  assign fout        = fout_q;
  assign n_active    = n_active_q;
  assign period_done = period_done_q;
  assign n_err       = n_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_freq_gen_n.sv
// Bench for freq_gen_n: a vector table for short cases plus hand-written
// sequences whose expectations come from period arithmetic.
module tb_freq_gen_n;

  localparam int N_W = 15;
  localparam int EW  = N_W + 4;

  // clock / reset block
  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           en = 1'b0;
  logic [N_W-1:0] n_in = '0;
  logic           n_load = 1'b0;
  logic           fout;
  logic [N_W-1:0] n_active;
  logic           period_done;
  logic           n_err;
  logic           busy;

  always #5 clk = ~clk;

  freq_gen_n #(.N_W(N_W)) dut (
    .clk(clk), .reset(reset), .en(en), .n_in(n_in), .n_load(n_load),
    .fout(fout), .n_active(n_active), .period_done(period_done),
    .n_err(n_err), .busy(busy)
  );

  // scoreboard: packed {fout, period_done, n_err, busy, n_active}
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic           rst;
    logic           en;
    logic           ld;
    logic [N_W-1:0] nin;
    logic           e_fout;
    logic           e_pd;
    logic           e_err;
    logic           e_busy;
    logic [N_W-1:0] e_na;
  } vec_t;

  vec_t vtab[21];

  // Drive one cycle, push the outputs expected after the edge, then check.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic ld, input logic [N_W-1:0] nin,
                      input logic ef, input logic epd, input logic eerr,
                      input logic eb, input logic [N_W-1:0] ena);
    logic [EW-1:0] act, exp_v;
    reset  = r;
    en     = e;
    n_load = ld;
    n_in   = nin;
    exp_q.push_back({ef, epd, eerr, eb, ena});
    @(posedge clk);
    #1;
    act   = {fout, period_done, n_err, busy, n_active};
    exp_v = exp_q.pop_front();
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s t=%0t got fout=%b pd=%b err=%b busy=%b na=%0d want fout=%b pd=%b err=%b busy=%b na=%0d",
               tag, $time, act[EW-1], act[EW-2], act[EW-3], act[EW-4], act[N_W-1:0],
               exp_v[EW-1], exp_v[EW-2], exp_v[EW-3], exp_v[EW-4], exp_v[N_W-1:0]);
    end
  endtask

  // Running generator with half-period n, at position pos within its period.
  task automatic run_step(input string tag, input logic e, input logic ld,
                          input int nin, input int n, input int pos,
                          input logic eerr);
    step(tag, 1'b0, e, ld, N_W'(nin), (pos % (2*n)) < n,
         (pos % (2*n)) == (2*n - 1), eerr, 1'b1, N_W'(n));
  endtask

  task automatic reset_and_load(input string tag, input int n);
    step(tag, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(tag, 1'b0, 1'b0, 1'b1, N_W'(n), 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    //            rst  en   ld   nin  fout pd   err  busy na
    vtab[0]  = '{1'b1,1'b0,1'b0,  0, 1'b0,1'b0,1'b0,1'b0, 0};
    vtab[1]  = '{1'b1,1'b1,1'b1,  5, 1'b0,1'b0,1'b0,1'b0, 0};
    vtab[2]  = '{1'b0,1'b1,1'b0,  0, 1'b0,1'b0,1'b0,1'b0, 0};
    vtab[3]  = '{1'b0,1'b1,1'b1,  0, 1'b0,1'b0,1'b1,1'b0, 0};
    vtab[4]  = '{1'b0,1'b0,1'b1,  3, 1'b0,1'b0,1'b0,1'b0, 0};
    vtab[5]  = '{1'b0,1'b0,1'b0,  0, 1'b0,1'b0,1'b0,1'b0, 0};
    vtab[6]  = '{1'b0,1'b1,1'b0,  0, 1'b1,1'b0,1'b0,1'b1, 3};
    vtab[7]  = '{1'b0,1'b1,1'b1,  2, 1'b1,1'b0,1'b0,1'b1, 3};
    vtab[8]  = '{1'b0,1'b1,1'b0,  0, 1'b1,1'b0,1'b0,1'b1, 3};
    vtab[9]  = '{1'b0,1'b1,1'b0,  0, 1'b0,1'b0,1'b0,1'b1, 3};
    vtab[10] = '{1'b0,1'b1,1'b0,  0, 1'b0,1'b0,1'b0,1'b1, 3};
    vtab[11] = '{1'b0,1'b1,1'b0,  0, 1'b0,1'b1,1'b0,1'b1, 3};
    vtab[12] = '{1'b0,1'b1,1'b0,  0, 1'b1,1'b0,1'b0,1'b1, 2};
    vtab[13] = '{1'b0,1'b0,1'b0,  0, 1'b1,1'b0,1'b0,1'b1, 2};
    vtab[14] = '{1'b0,1'b0,1'b0,  0, 1'b0,1'b0,1'b0,1'b1, 2};
    vtab[15] = '{1'b0,1'b0,1'b0,  0, 1'b0,1'b1,1'b0,1'b1, 2};
    vtab[16] = '{1'b0,1'b0,1'b0,  0, 1'b0,1'b0,1'b0,1'b0, 2};
    vtab[17] = '{1'b0,1'b1,1'b1,  1, 1'b1,1'b0,1'b0,1'b1, 1};
    vtab[18] = '{1'b0,1'b1,1'b0,  0, 1'b0,1'b1,1'b0,1'b1, 1};
    vtab[19] = '{1'b0,1'b1,1'b0,  0, 1'b1,1'b0,1'b0,1'b1, 1};
    vtab[20] = '{1'b1,1'b1,1'b0,  0, 1'b0,1'b0,1'b0,1'b0, 0};

    for (int i = 0; i < 21; i++)
      step($sformatf("table[%0d]", i), vtab[i].rst, vtab[i].en, vtab[i].ld,
           vtab[i].nin, vtab[i].e_fout, vtab[i].e_pd, vtab[i].e_err,
           vtab[i].e_busy, vtab[i].e_na);

    // N=5 basic pattern over three periods
    reset_and_load("n5_load", 5);
    for (int k = 0; k < 30; k++) run_step("n5_run", 1'b1, 1'b0, 0, 5, k, 1'b0);

    // N=1: clk/2 output
    reset_and_load("n1_load", 1);
    for (int k = 0; k < 20; k++) run_step("n1_run", 1'b1, 1'b0, 0, 1, k, 1'b0);

    // Reload mid-period: 5 -> 8 at boundary, then 3 and 9 -> 9 wins
    reset_and_load("reload_load", 5);
    for (int k = 0; k < 44; k++) begin
      int ld_v;
      ld_v = (k == 2) ? 8 : (k == 12) ? 3 : (k == 14) ? 9 : 0;
      if (k < 10)      run_step("reload_n5", 1'b1, ld_v != 0, ld_v, 5, k, 1'b0);
      else if (k < 26) run_step("reload_n8", 1'b1, ld_v != 0, ld_v, 8, k - 10, 1'b0);
      else             run_step("reload_n9", 1'b1, ld_v != 0, ld_v, 9, k - 26, 1'b0);
    end

    // Zero load while running N=4
    reset_and_load("zero_load", 4);
    for (int k = 0; k < 24; k++)
      run_step("zero_run", 1'b1, k == 5, 0, 4, k, k == 5);

    // N=6, en dropped on 3rd HIGH cycle: period completes then IDLE
    reset_and_load("drop_load", 6);
    for (int k = 0; k < 12; k++) run_step("drop_run", k < 3, 1'b0, 0, 6, k, 1'b0);
    for (int k = 0; k < 4; k++)
      step("drop_idle", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, N_W'(6));

    // Same, en re-raised on 2nd LOW cycle: no gap
    for (int k = 0; k < 30; k++)
      run_step("reraise_run", (k < 3) || (k >= 8), 1'b0, 0, 6, k, 1'b0);

    // Reset during HIGH with N=7, then stay IDLE without a load
    reset_and_load("rst_load", 7);
    for (int k = 0; k < 3; k++) run_step("rst_run", 1'b1, 1'b0, 0, 7, k, 1'b0);
    step("rst_mid", 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 5; k++)
      step("rst_idle", 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
